sdram_client_arbiter: RTL and testbench

- Round-robin front-end that shares one port of the multi-port `sdram` controller among NUM_CLIENTS requesters (video fetch, CPU, DMA, and others).
- Captures single-word read/write requests per client and issues one request at a time on the controller port using the controller's available/ready handshake.
- Returns read data and a completion pulse to the owning client.
- Sits between client logic and one `port_*` slot of `sdram`.

---
 rtl/sdram_arb_pkg.sv | 35 +++
 rtl/sdram_client_arbiter_rr_pick.sv | 40 ++++
 rtl/sdram_client_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_client_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Purpose  : Shared types and widths for the SDRAM client arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int ARB_NUM_CLIENTS = 4;
    localparam int ARB_ADDR_W      = 21;
    localparam int ARB_DATA_W      = 32;
    localparam int ARB_DQM_W       = 4;

    // A one-client arbiter still needs a 1-bit index to stay legal.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CLIENT_IDX_W = idx_width(ARB_NUM_CLIENTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] data;
        logic [ARB_DQM_W-1:0]  byte_en;
        logic                  is_wr;
    } arb_req_t;

endpackage
`default_nettype wire

// File: rtl/sdram_client_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker: first pending slot at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_CLIENTS-1:0] pending,
    input  logic [IDX_W-1:0]       ptr,
    output logic                   grant_valid,
    output logic [IDX_W-1:0]       grant_idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest offset down so the nearest pending slot wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            cand_idx = IDX_W'(cand);
            if (pending[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_client_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_client_arbiter
// Purpose  : Round-robin sharing of one sdram controller port among clients.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_client_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = ARB_NUM_CLIENTS,
    parameter int ADDR_WIDTH  = ARB_ADDR_W,
    parameter int DATA_WIDTH  = ARB_DATA_W,
    parameter int DQM_WIDTH   = ARB_DQM_W
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] cl_addr,
    input  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] cl_data,
    input  logic [NUM_CLIENTS-1:0][DQM_WIDTH-1:0]  cl_byte_en,
    input  logic [NUM_CLIENTS-1:0]                 cl_wr,
    input  logic [NUM_CLIENTS-1:0]                 cl_rd,
    output logic [NUM_CLIENTS-1:0]                 cl_busy,
    output logic [NUM_CLIENTS-1:0]                 cl_done,
    output logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] cl_q,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [DATA_WIDTH-1:0]                  mem_data,
    output logic [DQM_WIDTH-1:0]                   mem_byte_en,
    output logic                                   mem_wr,
    output logic                                   mem_rd,
    input  logic                                   mem_available,
    input  logic                                   mem_ready,
    input  logic [DATA_WIDTH-1:0]                  mem_q
);

    localparam int IDX_W = idx_width(NUM_CLIENTS);

    arb_state_t                            state_q, state_d;
    logic [IDX_W-1:0]                      ptr_q, ptr_d;
    logic [IDX_W-1:0]                      grant_q, grant_d;
    logic [NUM_CLIENTS-1:0]                pend_q, pend_d;
    logic [NUM_CLIENTS-1:0]                done_q, done_d;
    arb_req_t [NUM_CLIENTS-1:0]            slot_q, slot_d;
    logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    arb_req_t                              mreq_q, mreq_d;
    logic                                  mwr_q, mwr_d;
    logic                                  mrd_q, mrd_d;

    logic [NUM_CLIENTS-1:0] w_eligible;
    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_pick_idx;

    // A slot finishing this cycle is still marked pending but must not be re-granted.
    assign w_eligible = pend_q & ~done_q;

    rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .pending     (w_eligible),
        .ptr         (ptr_q),
        .grant_valid (w_pick_valid),
        .grant_idx   (w_pick_idx)
    );

    // Slots free up the cycle after the done pulse, so a strobe seen with done is dropped.
    always_comb begin
        pend_d = pend_q;
        slot_d = slot_q;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (done_q[i]) begin
                pend_d[i] = 1'b0;
            end else if (!pend_q[i] && (cl_wr[i] || cl_rd[i])) begin
                pend_d[i]         = 1'b1;
                slot_d[i].addr    = cl_addr[i];
                slot_d[i].data    = cl_data[i];
                slot_d[i].byte_en = cl_byte_en[i];
                slot_d[i].is_wr   = cl_wr[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        rdata_d = rdata_q;
        mreq_d  = mreq_q;
        mwr_d   = mwr_q;
        mrd_d   = mrd_q;
        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    grant_d = w_pick_idx;
                    mreq_d  = slot_q[w_pick_idx];
                    mwr_d   = slot_q[w_pick_idx].is_wr;
                    mrd_d   = !slot_q[w_pick_idx].is_wr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_available) begin
                    mwr_d   = 1'b0;
                    mrd_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    if (!mreq_q.is_wr) begin
                        rdata_d[grant_q] = mem_q;
                    end
                    done_d[grant_q] = 1'b1;
                    ptr_d   = (grant_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            pend_q  <= '0;
            done_q  <= '0;
            slot_q  <= '0;
            rdata_q <= '0;
            mreq_q  <= '0;
            mwr_q   <= 1'b0;
            mrd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            slot_q  <= slot_d;
            rdata_q <= rdata_d;
            mreq_q  <= mreq_d;
            mwr_q   <= mwr_d;
            mrd_q   <= mrd_d;
        end
    end

    assign cl_busy     = pend_q;
    assign cl_done     = done_q;
    assign cl_q        = rdata_q;
    assign mem_addr    = mreq_q.addr;
    assign mem_data    = mreq_q.data;
    assign mem_byte_en = mreq_q.byte_en;
    assign mem_wr      = mwr_q;
    assign mem_rd      = mrd_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_client_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_client_arbiter
// Purpose  : Self-checking bench for sdram_client_arbiter with an sdram port model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_client_arbiter;

    localparam int N  = 4;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0][AW-1:0] cl_addr;
    logic [N-1:0][DW-1:0] cl_data;
    logic [N-1:0][BW-1:0] cl_byte_en;
    logic [N-1:0]         cl_wr, cl_rd;
    logic [N-1:0]         cl_busy, cl_done;
    logic [N-1:0][DW-1:0] cl_q;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_data;
    logic [BW-1:0]        mem_byte_en;
    logic                 mem_wr, mem_rd;
    logic                 mem_available;
    logic                 mem_ready = 1'b0;
    logic [DW-1:0]        mem_q = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdram_client_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cl_addr       (cl_addr),
        .cl_data       (cl_data),
        .cl_byte_en    (cl_byte_en),
        .cl_wr         (cl_wr),
        .cl_rd         (cl_rd),
        .cl_busy       (cl_busy),
        .cl_done       (cl_done),
        .cl_q          (cl_q),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_byte_en   (mem_byte_en),
        .mem_wr        (mem_wr),
        .mem_rd        (mem_rd),
        .mem_available (mem_available),
        .mem_ready     (mem_ready),
        .mem_q         (mem_q)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- sdram port model: ready the cycle after acceptance ----
    logic resp_en = 1'b1;
    logic force_ready = 1'b0;
    int   n_accepts = 0;
    logic [DW-1:0] sdram_mem [int];

    always @(posedge clk) begin : p_sdram
        logic          acc;
        logic          is_rd;
        logic [DW-1:0] word;
        acc   = resp_en && reset_n && (mem_wr || mem_rd) && mem_available;
        is_rd = mem_rd;
        word  = '0;
        if (reset_n && (mem_wr || mem_rd) && mem_available) n_accepts++;
        if (acc) begin
            word = sdram_mem.exists(int'(mem_addr)) ? sdram_mem[int'(mem_addr)] : '0;
            if (mem_wr) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byte_en[b]) word[8*b +: 8] = mem_data[8*b +: 8];
                sdram_mem[int'(mem_addr)] = word;
            end
        end
        #2;
        mem_ready = acc || force_ready;
        if (acc && is_rd) mem_q = word;
    end

    // ---------------- behavioural model and per-cycle compare ---------------
    logic [N-1:0]         m_busy, m_done;
    logic [N-1:0][DW-1:0] m_q;
    logic [AW-1:0]        s_addr [N];
    logic [DW-1:0]        s_data [N];
    logic [BW-1:0]        s_be   [N];
    logic                 s_wr   [N];
    int                   m_phase, m_g, m_ptr;
    logic                 m_wr, m_rd, m_op_wr;
    logic [AW-1:0]        m_addr;
    logic [DW-1:0]        m_data;
    logic [BW-1:0]        m_be;

    always @(negedge clk) begin : p_model
        logic [N-1:0]         n_busy, n_done;
        logic [N-1:0][DW-1:0] n_q;
        int                   c;
        bit                   found;
        if (!reset_n) begin
            m_busy = '0; m_done = '0; m_q = '0;
            m_phase = 0; m_g = 0; m_ptr = 0;
            m_wr = 1'b0; m_rd = 1'b0; m_op_wr = 1'b0;
            m_addr = '0; m_data = '0; m_be = '0;
            for (int i = 0; i < N; i++) begin
                s_addr[i] = '0; s_data[i] = '0; s_be[i] = '0; s_wr[i] = 1'b0;
            end
        end
        check("busy", cl_busy, m_busy);
        check("done", cl_done, m_done);
        for (int i = 0; i < N; i++) check("cl_q", cl_q[i], m_q[i]);
        check("mem_wr", mem_wr, m_wr);
        check("mem_rd", mem_rd, m_rd);
        check("mem_addr", mem_addr, m_addr);
        check("mem_data", mem_data, m_data);
        check("mem_byte_en", mem_byte_en, m_be);
        if (reset_n) begin
            n_busy = m_busy; n_done = '0; n_q = m_q;
            if (m_phase == 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && m_busy[c] && !m_done[c]) begin
                        found = 1; m_g = c; m_phase = 1;
                        m_op_wr = s_wr[c]; m_wr = s_wr[c]; m_rd = !s_wr[c];
                        m_addr = s_addr[c]; m_data = s_data[c]; m_be = s_be[c];
                    end
                end
            end else if (m_phase == 1) begin
                if (mem_available) begin
                    m_wr = 1'b0; m_rd = 1'b0; m_phase = 2;
                end
            end else if (mem_ready) begin
                if (!m_op_wr) n_q[m_g] = mem_q;
                n_done[m_g] = 1'b1;
                m_ptr = (m_g + 1) % N;
                m_phase = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_done[i]) n_busy[i] = 1'b0;
                else if (!m_busy[i] && (cl_wr[i] || cl_rd[i])) begin
                    n_busy[i] = 1'b1;
                    s_addr[i] = cl_addr[i]; s_data[i] = cl_data[i];
                    s_be[i] = cl_byte_en[i]; s_wr[i] = cl_wr[i];
                end
            end
            m_busy = n_busy; m_done = n_done; m_q = n_q;
        end
    end

    // ---------------- transaction logs ----------------
    int            done_log[$];
    logic [AW-1:0] issue_addr_log[$];
    logic          issue_wr_log[$];
    logic          prev_strobe = 1'b0;

    always @(negedge clk) begin : p_log
        if ((mem_wr || mem_rd) && !prev_strobe) begin
            issue_addr_log.push_back(mem_addr);
            issue_wr_log.push_back(mem_wr);
        end
        prev_strobe = mem_wr || mem_rd;
        for (int i = 0; i < N; i++) if (cl_done[i]) done_log.push_back(i);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int idx, input int budget, input string name);
        int k;
        k = 0;
        while (!cl_done[idx] && k < budget) begin
            tick();
            k++;
        end
        check(name, cl_done[idx], 1'b1);
    endtask

    initial begin : p_main
        int k;
        int acc_before;
        int log_before;
        int exp_order[5];
        int got_v;
        exp_order = '{0, 1, 2, 3, 0};
        cl_addr = '0; cl_data = '0; cl_byte_en = '0; cl_wr = '0; cl_rd = '0;
        mem_available = 1'b1;
        repeat (3) tick();
        check("rst_busy", cl_busy, 0);
        check("rst_done", cl_done, 0);
        check("rst_mem_strobes", {mem_wr, mem_rd}, 0);
        reset_n = 1'b1;
        tick();

        // single write from client 0
        cl_addr[0] = 21'h002020; cl_data[0] = 32'h1234; cl_byte_en[0] = 4'hf; cl_wr[0] = 1'b1;
        tick();
        cl_wr[0] = 1'b0;
        check("wr_busy_set", cl_busy[0], 1'b1);
        tick();
        check("wr_mem_wr", mem_wr, 1'b1);
        check("wr_mem_addr", mem_addr, 21'h002020);
        check("wr_mem_data", mem_data, 32'h1234);
        check("wr_mem_be", mem_byte_en, 4'hf);
        wait_done(0, 10, "wr_done0");
        check("wr_busy_during_done", cl_busy[0], 1'b1);
        tick();
        check("wr_busy_clear", cl_busy[0], 1'b0);
        check("wr_done_one_cycle", cl_done[0], 1'b0);
        check("wr_sdram_word", sdram_mem[int'(21'h002020)], 32'h1234);

        // read-back by client 1
        cl_addr[1] = 21'h002020; cl_rd[1] = 1'b1;
        tick();
        cl_rd[1] = 1'b0;
        wait_done(1, 10, "rd_done1");
        check("rd_q1", cl_q[1], 32'h1234);
        repeat (3) tick();
        check("rd_q1_held", cl_q[1], 32'h1234);

        // contention from pointer 0, then client 0 re-requests
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        done_log.delete();
        issue_addr_log.delete();
        issue_wr_log.delete();
        for (int i = 0; i < N; i++) begin
            cl_addr[i] = AW'(32'h100 + i);
            cl_rd[i] = 1'b1;
        end
        tick();
        cl_rd = '0;
        wait_done(0, 20, "cont_done0");
        cl_rd[0] = 1'b1;
        repeat (2) tick();
        cl_rd[0] = 1'b0;
        k = 0;
        while (done_log.size() < 5 && k < 60) begin
            tick();
            k++;
        end
        repeat (6) tick();
        check("cont_done_count", done_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            got_v = (i < done_log.size()) ? done_log[i] : -1;
            check("cont_done_order", got_v, exp_order[i]);
            got_v = (i < issue_addr_log.size()) ? int'(issue_addr_log[i]) : -1;
            check("cont_issue_addr", got_v, 32'h100 + exp_order[i]);
        end

        // stall during ISSUE
        mem_available = 1'b0;
        acc_before = n_accepts;
        cl_addr[1] = 21'h002020; cl_rd[1] = 1'b1;
        tick();
        cl_rd[1] = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            check("stall_mem_rd", mem_rd, 1'b1);
            check("stall_mem_addr", mem_addr, 21'h002020);
            tick();
        end
        mem_available = 1'b1;
        wait_done(1, 10, "stall_done1");
        check("stall_accepts", n_accepts - acc_before, 1);
        check("stall_q1", cl_q[1], 32'h1234);

        // write+read together, then a read while busy
        acc_before = n_accepts;
        log_before = issue_wr_log.size();
        cl_addr[2] = 21'h000300; cl_data[2] = 32'hCAFE_F00D; cl_byte_en[2] = 4'hf;
        cl_wr[2] = 1'b1; cl_rd[2] = 1'b1;
        tick();
        cl_wr[2] = 1'b0; cl_rd[2] = 1'b0;
        tick();
        cl_rd[2] = 1'b1;
        tick();
        cl_rd[2] = 1'b0;
        wait_done(2, 10, "conf_done2");
        repeat (8) tick();
        check("conf_accepts", n_accepts - acc_before, 1);
        check("conf_issues", issue_wr_log.size() - log_before, 1);
        check("conf_is_write", issue_wr_log[issue_wr_log.size() - 1], 1'b1);
        check("conf_sdram_word", sdram_mem[int'(21'h000300)], 32'hCAFE_F00D);
        check("conf_busy_clear", cl_busy[2], 1'b0);

        // reset while waiting for mem_ready
        resp_en = 1'b0;
        cl_addr[3] = 21'h000400; cl_data[3] = 32'hDEAD_BEEF; cl_byte_en[3] = 4'h3; cl_wr[3] = 1'b1;
        tick();
        cl_wr[3] = 1'b0;
        k = 0;
        while (!mem_wr && k < 10) begin tick(); k++; end
        check("rstw_issue", mem_wr, 1'b1);
        k = 0;
        while (mem_wr && k < 10) begin tick(); k++; end
        check("rstw_accepted", mem_wr, 1'b0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("rstw_busy", cl_busy, 0);
        check("rstw_done", cl_done, 0);
        check("rstw_q_zero", |cl_q, 1'b0);
        check("rstw_mem", {mem_wr, mem_rd, mem_addr, mem_data, mem_byte_en}, 0);
        tick();
        reset_n = 1'b1;
        force_ready = 1'b1;
        tick();
        force_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstw_no_done", cl_done, 0);
        end
        resp_en = 1'b1;
        cl_addr[3] = 21'h002020; cl_rd[3] = 1'b1;
        tick();
        cl_rd[3] = 1'b0;
        wait_done(3, 10, "rstw_done3");
        check("rstw_q3", cl_q[3], 32'h1234);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
